// File: rtl/sram_fifo_pkg.sv
// Shared SRAM geometry and FIFO access-type definitions for the sram_fifo slice.
// The sram storage block uses the same SRAM_* geometry constants.
package sram_fifo_pkg;

    localparam int SRAM_DW    = 8;
    localparam int SRAM_AW    = 8;
    localparam int SRAM_DEPTH = 1 << SRAM_AW;

    localparam int DW = SRAM_DW;
    localparam int AW = SRAM_AW;

    localparam logic [AW-1:0] PTR_ONE   = {{(AW-1){1'b0}}, 1'b1};
    localparam logic [AW:0]   CNT_ONE   = {{AW{1'b0}}, 1'b1};
    localparam logic [AW:0]   CNT_ZERO  = {(AW+1){1'b0}};
    localparam logic [AW:0]   CNT_FULL  = {1'b1, {AW{1'b0}}};

    typedef enum logic [1:0] {
        ACC_IDLE  = 2'd0,
        ACC_WRITE = 2'd1,
        ACC_READ  = 2'd2
    } acc_e;

    // Single-port SRAM: a read always wins over a write in the same cycle.
    function automatic acc_e sel_access(input logic push_acc, input logic pop_acc);
        acc_e acc;
        if (pop_acc) begin
            acc = ACC_READ;
        end else if (push_acc) begin
            acc = ACC_WRITE;
        end else begin
            acc = ACC_IDLE;
        end
        return acc;
    endfunction

endpackage

// File: rtl/sram_fifo_if.sv
// Push/pop client handshake of sram_fifo; master is the client, slave is the FIFO.
import sram_fifo_pkg::*;

interface sram_fifo_if;
    logic          push;
    logic [DW-1:0] push_data;
    logic          push_ready;
    logic          pop;
    logic          pop_ready;
    logic [DW-1:0] pop_data;
    logic          pop_valid;
    logic          empty;
    logic          full;
    logic [AW:0]   count;

    modport master (
        output push, push_data, pop,
        input  push_ready, pop_ready, pop_data, pop_valid, empty, full, count
    );

    modport slave (
        input  push, push_data, pop,
        output push_ready, pop_ready, pop_data, pop_valid, empty, full, count
    );
endinterface

// File: rtl/sram_fifo_ptr.sv
// fifo_ptr: read/write pointers, occupancy count, push/pop arbitration and flags.
// Pop has priority; a push colliding with an acceptable pop is stalled.
module fifo_ptr
    import sram_fifo_pkg::*;
(
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push,
    input  logic          pop,
    output logic          push_ready,
    output logic          pop_ready,
    output logic          empty,
    output logic          full,
    output logic          push_acc,
    output logic          pop_acc,
    output logic [AW-1:0] wptr,
    output logic [AW-1:0] rptr,
    output logic [AW:0]   count
);

    logic [AW-1:0] wptr_r;
    logic [AW-1:0] rptr_r;
    logic [AW:0]   count_r;
    logic          empty_s;
    logic          full_s;
    logic          pop_acc_s;
    logic          push_acc_s;

    // Flags and acceptance decode from the registered count.
    always_comb begin
        empty_s    = (count_r == CNT_ZERO);
        full_s     = (count_r == CNT_FULL);
        pop_acc_s  = pop && !empty_s;
        push_acc_s = push && !full_s && !pop_acc_s;
    end

    // Pointer and occupancy state; pointers wrap naturally at AW bits.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_r  <= {AW{1'b0}};
            rptr_r  <= {AW{1'b0}};
            count_r <= CNT_ZERO;
        end else begin
            if (push_acc_s) begin
                wptr_r  <= wptr_r + PTR_ONE;
                count_r <= count_r + CNT_ONE;
            end else if (pop_acc_s) begin
                rptr_r  <= rptr_r + PTR_ONE;
                count_r <= count_r - CNT_ONE;
            end else begin
                wptr_r  <= wptr_r;
                rptr_r  <= rptr_r;
                count_r <= count_r;
            end
        end
    end

    assign push_ready = !full_s && !(pop && !empty_s);
    assign pop_ready  = !empty_s;
    assign empty      = empty_s;
    assign full       = full_s;
    assign push_acc   = push_acc_s;
    assign pop_acc    = pop_acc_s;
    assign wptr       = wptr_r;
    assign rptr       = rptr_r;
    assign count      = count_r;

endmodule

// File: rtl/sram_fifo.sv
// sram_fifo: turns a push/pop handshake into registered single-port SRAM cycles.
// Popped data is captured from the asynchronous SRAM read and presented two cycles after acceptance.
module sram_fifo
    import sram_fifo_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    sram_fifo_if.slave        fif,
    output logic              sram_cs,
    output logic              sram_wr,
    output logic              sram_rd,
    output logic [AW-1:0]     sram_addr,
    output logic [DW-1:0]     sram_din,
    input  logic [DW-1:0]     sram_dout
);

    logic          push_acc_s;
    logic          pop_acc_s;
    logic [AW-1:0] wptr_s;
    logic [AW-1:0] rptr_s;
    acc_e          acc_s;

    logic          sram_cs_r;
    logic          sram_wr_r;
    logic          sram_rd_r;
    logic [AW-1:0] sram_addr_r;
    logic [DW-1:0] sram_din_r;
    logic [DW-1:0] pop_data_r;
    logic          pop_valid_r;

    fifo_ptr u_ptr (
        .clk        (clk),
        .rst_n      (rst_n),
        .push       (fif.push),
        .pop        (fif.pop),
        .push_ready (fif.push_ready),
        .pop_ready  (fif.pop_ready),
        .empty      (fif.empty),
        .full       (fif.full),
        .push_acc   (push_acc_s),
        .pop_acc    (pop_acc_s),
        .wptr       (wptr_s),
        .rptr       (rptr_s),
        .count      (fif.count)
    );

    // Select this cycle's SRAM access from the arbitration result.
    always_comb begin
        acc_s = sel_access(push_acc_s, pop_acc_s);
    end

    // Registered SRAM bus; address and write data hold when idle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sram_cs_r   <= 1'b0;
            sram_wr_r   <= 1'b0;
            sram_rd_r   <= 1'b0;
            sram_addr_r <= {AW{1'b0}};
            sram_din_r  <= {DW{1'b0}};
        end else begin
            case (acc_s)
                ACC_WRITE: begin
                    sram_cs_r   <= 1'b1;
                    sram_wr_r   <= 1'b1;
                    sram_rd_r   <= 1'b0;
                    sram_addr_r <= wptr_s;
                    sram_din_r  <= fif.push_data;
                end
                ACC_READ: begin
                    sram_cs_r   <= 1'b1;
                    sram_wr_r   <= 1'b0;
                    sram_rd_r   <= 1'b1;
                    sram_addr_r <= rptr_s;
                    sram_din_r  <= sram_din_r;
                end
                default: begin
                    sram_cs_r   <= 1'b0;
                    sram_wr_r   <= 1'b0;
                    sram_rd_r   <= 1'b0;
                    sram_addr_r <= sram_addr_r;
                    sram_din_r  <= sram_din_r;
                end
            endcase
        end
    end

    // Capture read data at the end of the SRAM read cycle and pulse pop_valid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pop_data_r  <= {DW{1'b0}};
            pop_valid_r <= 1'b0;
        end else begin
            pop_valid_r <= sram_cs_r && sram_rd_r;
            if (sram_cs_r && sram_rd_r) begin
                pop_data_r <= sram_dout;
            end else begin
                pop_data_r <= pop_data_r;
            end
        end
    end

    assign sram_cs       = sram_cs_r;
    assign sram_wr       = sram_wr_r;
    assign sram_rd       = sram_rd_r;
    assign sram_addr     = sram_addr_r;
    assign sram_din      = sram_din_r;
    assign fif.pop_data  = pop_data_r;
    assign fif.pop_valid = pop_valid_r;

endmodule

// File: tb/tb_sram_fifo.sv
// Self-checking bench for sram_fifo: cycle-level FIFO model, SRAM model and pop-data scoreboard.
module tb_sram_fifo;
    import sram_fifo_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    sram_fifo_if fif();

    logic          sram_cs, sram_wr, sram_rd;
    logic [AW-1:0] sram_addr;
    logic [DW-1:0] sram_din;
    logic [DW-1:0] sram_dout;
    logic [DW-1:0] mem [SRAM_DEPTH];

    sram_fifo dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .fif       (fif),
        .sram_cs   (sram_cs),
        .sram_wr   (sram_wr),
        .sram_rd   (sram_rd),
        .sram_addr (sram_addr),
        .sram_din  (sram_din),
        .sram_dout (sram_dout)
    );

    always @(posedge clk) begin
        if (sram_cs && sram_wr) mem[sram_addr] <= sram_din;
    end
    assign sram_dout = (sram_cs && sram_rd) ? mem[sram_addr] : 8'h00;

    typedef struct {
        logic [7:0] data;
        int         due;
    } exp_t;

    exp_t       exp_q[$];
    logic [7:0] model_q[$];
    logic [7:0] m_wptr, m_rptr;
    logic       e_cs, e_wr, e_rd;
    logic [7:0] e_addr, e_din;
    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int run_len = 0;
    logic prev_v = 1'b0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard monitor: pop_valid must pulse exactly on the due cycle with the expected data.
    always @(negedge clk) begin
        logic want;
        want = (exp_q.size() > 0) && (exp_q[0].due == cyc);
        check_val("pop_valid", 32'(fif.pop_valid), 32'(want));
        if (want) begin
            check_val("pop_data", 32'(fif.pop_data), 32'(exp_q[0].data));
            void'(exp_q.pop_front());
        end
        if (fif.pop_valid) run_len = prev_v ? run_len + 1 : 1;
        prev_v = fif.pop_valid;
    end

    task automatic model_reset();
        model_q.delete();
        exp_q.delete();
        m_wptr = 8'd0; m_rptr = 8'd0;
        e_cs = 1'b0; e_wr = 1'b0; e_rd = 1'b0;
        e_addr = 8'd0; e_din = 8'd0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check_val({tag, "_cs"},    32'(sram_cs), 32'd0);
        check_val({tag, "_wr"},    32'(sram_wr), 32'd0);
        check_val({tag, "_rd"},    32'(sram_rd), 32'd0);
        check_val({tag, "_addr"},  32'(sram_addr), 32'd0);
        check_val({tag, "_din"},   32'(sram_din), 32'd0);
        check_val({tag, "_pv"},    32'(fif.pop_valid), 32'd0);
        check_val({tag, "_pd"},    32'(fif.pop_data), 32'd0);
        check_val({tag, "_count"}, 32'(fif.count), 32'd0);
        check_val({tag, "_empty"}, 32'(fif.empty), 32'd1);
        check_val({tag, "_full"},  32'(fif.full), 32'd0);
        check_val({tag, "_prdy"},  32'(fif.pop_ready), 32'd0);
        check_val({tag, "_wrdy"},  32'(fif.push_ready), 32'd1);
    endtask

    // One clock cycle: drive, check flags/bus against the model, then advance the model.
    task automatic step(input logic p, input logic [7:0] d, input logic q);
        logic m_pop, m_push;
        int   sz;
        exp_t e;
        fif.push = p; fif.push_data = d; fif.pop = q;
        @(negedge clk);
        check_val("sram_cs",   32'(sram_cs), 32'(e_cs));
        check_val("sram_wr",   32'(sram_wr), 32'(e_wr));
        check_val("sram_rd",   32'(sram_rd), 32'(e_rd));
        check_val("sram_addr", 32'(sram_addr), 32'(e_addr));
        check_val("sram_din",  32'(sram_din), 32'(e_din));
        sz = model_q.size();
        m_pop  = q && (sz > 0);
        m_push = p && (sz < SRAM_DEPTH) && !m_pop;
        check_val("push_ready", 32'(fif.push_ready), 32'((sz < SRAM_DEPTH) && !(q && (sz > 0))));
        check_val("pop_ready",  32'(fif.pop_ready), 32'(sz > 0));
        check_val("count",      32'(fif.count), 32'(sz));
        check_val("empty",      32'(fif.empty), 32'(sz == 0));
        check_val("full",       32'(fif.full), 32'(sz == SRAM_DEPTH));
        if (m_push) begin
            e_cs = 1'b1; e_wr = 1'b1; e_rd = 1'b0; e_addr = m_wptr; e_din = d;
            model_q.push_back(d);
            m_wptr++;
        end else if (m_pop) begin
            e_cs = 1'b1; e_wr = 1'b0; e_rd = 1'b1; e_addr = m_rptr;
            e.data = model_q.pop_front();
            e.due  = cyc + 2;
            exp_q.push_back(e);
            m_rptr++;
        end else begin
            e_cs = 1'b0; e_wr = 1'b0; e_rd = 1'b0;
        end
        @(posedge clk); #1;
    endtask

    initial begin
        rst_n = 1'b0;
        fif.push = 1'b0; fif.push_data = 8'h00; fif.pop = 1'b0;
        model_reset();
        #12;
        check_reset_outputs("rst");
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;

        // Idle, then pop while empty: no bus cycle, no pop_valid.
        repeat (3) step(1'b0, 8'h00, 1'b0);
        step(1'b0, 8'h00, 1'b1);
        repeat (3) step(1'b0, 8'h00, 1'b0);

        // Three pushes then three back-to-back pops.
        step(1'b1, 8'h11, 1'b0);
        step(1'b1, 8'h22, 1'b0);
        step(1'b1, 8'h33, 1'b0);
        repeat (3) step(1'b0, 8'h00, 1'b1);
        repeat (3) step(1'b0, 8'h00, 1'b0);
        check_val("b2b_run3", 32'(run_len), 32'd3);
        check_val("cnt_after3", 32'(fif.count), 32'd0);

        // Fill to 256 with random data, overflow attempt, then drain across pointer wrap.
        for (int i = 0; i < SRAM_DEPTH; i++) step(1'b1, 8'($urandom), 1'b0);
        check_val("full_flag", 32'(fif.full), 32'd1);
        check_val("full_count", 32'(fif.count), 32'd256);
        step(1'b1, 8'h5A, 1'b0);
        step(1'b0, 8'h00, 1'b0);
        check_val("ovf_count", 32'(fif.count), 32'd256);
        for (int i = 0; i < SRAM_DEPTH; i++) step(1'b0, 8'h00, 1'b1);
        repeat (3) step(1'b0, 8'h00, 1'b0);
        check_val("b2b_run256", 32'(run_len), 32'd256);
        check_val("drain_count", 32'(fif.count), 32'd0);
        check_val("drain_sb", 32'(exp_q.size()), 32'd0);

        // Simultaneous push and pop at count 5: pop wins, push lands next cycle.
        for (int i = 0; i < 5; i++) step(1'b1, 8'(8'hC0 + i), 1'b0);
        step(1'b1, 8'h77, 1'b1);
        step(1'b1, 8'h77, 1'b0);
        step(1'b0, 8'h00, 1'b0);
        check_val("collide_count", 32'(fif.count), 32'd5);
        repeat (5) step(1'b0, 8'h00, 1'b1);
        repeat (3) step(1'b0, 8'h00, 1'b0);

        // Push into empty FIFO, pop the very next cycle.
        step(1'b1, 8'hA5, 1'b0);
        step(1'b0, 8'h00, 1'b1);
        repeat (3) step(1'b0, 8'h00, 1'b0);
        check_val("a5_data", 32'(fif.pop_data), 32'hA5);

        // Reset one cycle after a pop is accepted: the read is dropped.
        step(1'b1, 8'h3C, 1'b0);
        step(1'b0, 8'h00, 1'b1);
        fif.pop = 1'b0;
        rst_n = 1'b0;
        model_reset();
        #1;
        check_reset_outputs("midrst");
        @(negedge clk); @(negedge clk);
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (4) step(1'b0, 8'h00, 1'b0);
        check_val("midrst_sb", 32'(exp_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
